// File: rtl/fifo_pkg.sv
// Shared FIFO parameters and the occupancy encoding used by the read-side
// stream adapter and its skid buffer.
package fifo_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ADDR_WIDTH = 4;
    localparam int unsigned SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_e;

    function automatic logic [1:0] occ_count(input occ_state_e s);
        return s;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream bundle; master drives valid/data, slave drives ready.
interface fifo_rd_stream_if #(
    parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH
) ();

    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/fifo_async.sv
// Dual-clock FIFO with Gray-coded pointers and two-flop synchronisers.
// Read data is registered: valid the cycle after rd_en.
module fifo_async #(
    parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = fifo_pkg::ADDR_WIDTH
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_empty
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   wbin_q, wgray_q, rbin_q, rgray_q;
    logic [ADDR_WIDTH:0]   rgray_s1_q, rgray_s2_q, wgray_s1_q, wgray_s2_q;
    logic                  do_wr, do_rd;

    function automatic logic [ADDR_WIDTH:0] bin2gray(input logic [ADDR_WIDTH:0] b);
        return b ^ (b >> 1);
    endfunction

    // Full when the write pointer has lapped the synchronised read pointer.
    assign wr_full  = (wgray_q == {~rgray_s2_q[ADDR_WIDTH:ADDR_WIDTH-1],
                                    rgray_s2_q[ADDR_WIDTH-2:0]});
    assign rd_empty = (rgray_q == wgray_s2_q);
    assign do_wr    = wr_en && !wr_full;
    assign do_rd    = rd_en && !rd_empty;

    always_ff @(posedge wr_clk) begin
        if (do_wr) begin
            mem_q[wbin_q[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            wbin_q     <= '0;
            wgray_q    <= '0;
            rgray_s1_q <= '0;
            rgray_s2_q <= '0;
        end else begin
            rgray_s1_q <= rgray_q;
            rgray_s2_q <= rgray_s1_q;
            if (do_wr) begin
                wbin_q  <= wbin_q + PTR_ONE;
                wgray_q <= bin2gray(wbin_q + PTR_ONE);
            end
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            rbin_q     <= '0;
            rgray_q    <= '0;
            wgray_s1_q <= '0;
            wgray_s2_q <= '0;
            rd_data    <= '0;
        end else begin
            wgray_s1_q <= wgray_q;
            wgray_s2_q <= wgray_s1_q;
            if (do_rd) begin
                rd_data <= mem_q[rbin_q[ADDR_WIDTH-1:0]];
                rbin_q  <= rbin_q + PTR_ONE;
                rgray_q <= bin2gray(rbin_q + PTR_ONE);
            end
        end
    end

endmodule

// File: rtl/fifo_skid_buf.sv
// Two-entry register buffer: head_q is always the oldest word and drives the
// stream directly; occupancy is tracked by a small EMPTY/ONE/TWO state machine.
module fifo_skid_buf #(
    parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    push_i,
    input  logic [DATA_WIDTH-1:0]   push_data_i,
    output fifo_pkg::occ_state_e    state_o,
    fifo_rd_stream_if.master        out
);

    import fifo_pkg::*;

    occ_state_e            state_q;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    logic                  pop;

    assign pop       = out.valid && out.ready;
    assign out.valid = (state_q != EMPTY);
    assign out.data  = head_q;
    assign state_o   = state_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push_i) begin
                        head_q  <= push_data_i;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (push_i && pop) begin
                        head_q <= push_data_i;
                    end else if (push_i) begin
                        tail_q  <= push_data_i;
                        state_q <= TWO;
                    end else if (pop) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    // Pop shifts tail forward; a simultaneous push refills tail.
                    if (pop) begin
                        head_q <= tail_q;
                        if (push_i) begin
                            tail_q <= push_data_i;
                        end else begin
                            state_q <= ONE;
                        end
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Converts FIFO pop/data (one-cycle read latency) into a valid/ready stream.
// Define FIFO_RD_STATS_EN to add the rd_count delivered-word counter.
module fifo_rd_stream #(
    parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  flush,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [31:0]           rd_count
`endif
);

    import fifo_pkg::*;

    fifo_rd_stream_if #(.DATA_WIDTH(DATA_WIDTH)) strm ();

    occ_state_e occ_state;
    logic       inflight_q;
    logic       push;
    logic       xfer;
    logic [2:0] pending;

    assign strm.ready = m_ready;
    assign m_valid    = strm.valid;
    assign m_data     = strm.data;
    assign xfer       = strm.valid && strm.ready;
    assign push       = inflight_q;

    // Words that will be buffered after this edge, counting the one still in flight.
    assign pending    = {1'b0, occ_count(occ_state)} + {2'b00, inflight_q} - {2'b00, xfer};
    assign fifo_rd_en = !fifo_empty && !flush && !rd_rst && (pending < 3'(SKID_DEPTH));

    always_ff @(posedge rd_clk) begin
        if (rd_rst || flush) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_en;
        end
    end

    fifo_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk_i       (rd_clk),
        .rst_i       (rd_rst),
        .clear_i     (flush),
        .push_i      (push),
        .push_data_i (fifo_rd_data),
        .state_o     (occ_state),
        .out         (strm.master)
    );

`ifdef FIFO_RD_STATS_EN
    logic [31:0] rd_count_q;

    // Flush drops buffered words but keeps the running delivery count.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            rd_count_q <= '0;
        end else if (xfer) begin
            rd_count_q <= rd_count_q + 32'd1;
        end
    end

    assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream fed by fifo_async (8-bit data, 16 deep).
module tb_fifo_rd_stream;

    import fifo_pkg::*;

    logic       rd_clk = 1'b0;
    logic       wr_clk = 1'b0;
    logic       rd_rst, fifo_rst, flush, wr_en;
    logic [7:0] wr_data;
    logic       fifo_full, fifo_empty, fifo_rd_en;
    logic [7:0] fifo_rd_data;
`ifdef FIFO_RD_STATS_EN
    logic [31:0] rd_count;
`endif
    int checks = 0;
    int errors = 0;

    fifo_rd_stream_if #(.DATA_WIDTH(8)) s_if ();

    always #5 rd_clk = ~rd_clk;
    always #7 wr_clk = ~wr_clk;

    fifo_async #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) u_fifo (
        .wr_clk   (wr_clk),
        .wr_rst   (fifo_rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wr_full  (fifo_full),
        .rd_clk   (rd_clk),
        .rd_rst   (fifo_rst),
        .rd_en    (fifo_rd_en),
        .rd_data  (fifo_rd_data),
        .rd_empty (fifo_empty)
    );

    fifo_rd_stream #(.DATA_WIDTH(8)) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .flush        (flush),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .m_valid      (s_if.valid),
        .m_data       (s_if.data),
        .m_ready      (s_if.ready)
`ifdef FIFO_RD_STATS_EN
        ,
        .rd_count     (rd_count)
`endif
    );

    always @(negedge rd_clk) begin
        if (!fifo_rst && !rd_rst) begin
            assert (!(fifo_rd_en && fifo_empty))
                else $error("FAIL rd_en_while_empty: fifo_rd_en=1 required 0");
            assert (!(dut.push && dut.u_buf.state_q == TWO && !dut.xfer))
                else $error("FAIL skid_overrun: capture with state TWO and no transfer");
        end
    end

    task automatic cyc();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic write_words(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge wr_clk);
            #1;
            wr_en   = 1'b1;
            wr_data = first + 8'(i);
        end
        @(posedge wr_clk);
        #1;
        wr_en = 1'b0;
        repeat (8) @(posedge rd_clk);
        #1;
        checks++; if (fifo_empty !== 1'b0) begin errors++; $display("FAIL fifo_fill: fifo_empty=%b required 0", fifo_empty); end
    endtask

    task automatic test_reset();
        repeat (4) cyc();
        @(negedge rd_clk);
        checks++; if (s_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: m_valid=%b required 0", s_if.valid); end
        checks++; if (s_if.data !== 8'h00) begin errors++; $display("FAIL reset_data: m_data=%h required 00", s_if.data); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: fifo_rd_en=%b required 0", fifo_rd_en); end
`ifdef FIFO_RD_STATS_EN
        checks++; if (rd_count !== 32'd0) begin errors++; $display("FAIL reset_count: rd_count=%0d required 0", rd_count); end
`endif
        cyc();
        fifo_rst = 1'b0;
        rd_rst   = 1'b0;
        cyc();
        @(negedge rd_clk);
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL idle_rd_en: fifo_rd_en=%b required 0", fifo_rd_en); end
    endtask

    task automatic test_stream();
        cyc();
        flush = 1'b1;
        s_if.ready = 1'b1;
        write_words(8'h01, 16);
        cyc();
        flush = 1'b0;
        @(negedge rd_clk);
        checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL stream_pop0: fifo_rd_en=%b required 1", fifo_rd_en); end
        checks++; if (s_if.valid !== 1'b0) begin errors++; $display("FAIL stream_lat0: m_valid=%b required 0", s_if.valid); end
        cyc();
        @(negedge rd_clk);
        checks++; if (s_if.valid !== 1'b0) begin errors++; $display("FAIL stream_lat1: m_valid=%b required 0", s_if.valid); end
        for (int i = 0; i < 16; i++) begin
            cyc();
            @(negedge rd_clk);
            checks++; if (s_if.valid !== 1'b1 || s_if.data !== 8'(i + 1)) begin
                errors++; $display("FAIL stream_word%0d: m_valid=%b m_data=%h required 1/%h", i, s_if.valid, s_if.data, 8'(i + 1));
            end
        end
        cyc();
        @(negedge rd_clk);
        checks++; if (s_if.valid !== 1'b0) begin errors++; $display("FAIL stream_end: m_valid=%b required 0", s_if.valid); end
    endtask

    task automatic test_stall();
        int pops;
        cyc();
        flush = 1'b1;
        s_if.ready = 1'b0;
        write_words(8'h01, 3);
        cyc();
        flush = 1'b0;
        pops = 0;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) cyc();
            @(negedge rd_clk);
            if (fifo_rd_en) pops++;
            if (c >= 2) begin
                checks++; if (s_if.valid !== 1'b1 || s_if.data !== 8'h01 || fifo_rd_en !== 1'b0) begin
                    errors++; $display("FAIL stall_hold%0d: m_valid=%b m_data=%h fifo_rd_en=%b required 1/01/0", c, s_if.valid, s_if.data, fifo_rd_en);
                end
            end
        end
        checks++; if (pops != 2) begin errors++; $display("FAIL stall_pops: pops=%0d required 2", pops); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            s_if.ready = 1'b1;
            @(negedge rd_clk);
            checks++; if (s_if.valid !== 1'b1 || s_if.data !== 8'(i + 1)) begin
                errors++; $display("FAIL stall_release%0d: m_valid=%b m_data=%h required 1/%h", i, s_if.valid, s_if.data, 8'(i + 1));
            end
        end
        cyc();
        @(negedge rd_clk);
        checks++; if (s_if.valid !== 1'b0) begin errors++; $display("FAIL stall_end: m_valid=%b required 0", s_if.valid); end
    endtask

    task automatic test_toggle();
        int         got;
        logic       stalled;
        logic [7:0] held;
        cyc();
        flush = 1'b1;
        s_if.ready = 1'b0;
        write_words(8'h40, 16);
        cyc();
        flush = 1'b0;
        got = 0;
        stalled = 1'b0;
        held = 8'h00;
        for (int c = 0; c < 80 && got < 16; c++) begin
            if (c > 0) cyc();
            s_if.ready = c[0];
            @(negedge rd_clk);
            if (stalled) begin
                checks++; if (s_if.valid !== 1'b1 || s_if.data !== held) begin
                    errors++; $display("FAIL toggle_stable%0d: m_valid=%b m_data=%h required 1/%h", c, s_if.valid, s_if.data, held);
                end
            end
            if (s_if.valid && s_if.ready) begin
                checks++; if (s_if.data !== 8'h40 + 8'(got)) begin
                    errors++; $display("FAIL toggle_word%0d: m_data=%h required %h", got, s_if.data, 8'h40 + 8'(got));
                end
                got++;
            end
            stalled = s_if.valid && !s_if.ready;
            held = s_if.data;
        end
        checks++; if (got != 16) begin errors++; $display("FAIL toggle_count: delivered=%0d required 16", got); end
        cyc();
        s_if.ready = 1'b1;
        @(negedge rd_clk);
        checks++; if (s_if.valid !== 1'b0) begin errors++; $display("FAIL toggle_extra: m_valid=%b required 0", s_if.valid); end
    endtask

    task automatic test_flush();
        cyc();
        flush = 1'b1;
        s_if.ready = 1'b0;
        write_words(8'h61, 4);
        cyc();
        flush = 1'b0;
        @(negedge rd_clk);
        checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL flush_pop0: fifo_rd_en=%b required 1", fifo_rd_en); end
        cyc();
        @(negedge rd_clk);
        checks++; if (fifo_rd_en !== 1'b1 || s_if.valid !== 1'b0) begin
            errors++; $display("FAIL flush_pop1: fifo_rd_en=%b m_valid=%b required 1/0", fifo_rd_en, s_if.valid);
        end
        cyc();
        flush = 1'b1;
        @(negedge rd_clk);
        checks++; if (s_if.valid !== 1'b1 || s_if.data !== 8'h61 || fifo_rd_en !== 1'b0) begin
            errors++; $display("FAIL flush_one: m_valid=%b m_data=%h fifo_rd_en=%b required 1/61/0", s_if.valid, s_if.data, fifo_rd_en);
        end
        cyc();
        flush = 1'b0;
        s_if.ready = 1'b1;
        @(negedge rd_clk);
        checks++; if (s_if.valid !== 1'b0 || fifo_rd_en !== 1'b1) begin
            errors++; $display("FAIL flush_after: m_valid=%b fifo_rd_en=%b required 0/1", s_if.valid, fifo_rd_en);
        end
        cyc();
        @(negedge rd_clk);
        checks++; if (s_if.valid !== 1'b0) begin errors++; $display("FAIL flush_gap: m_valid=%b required 0", s_if.valid); end
        cyc();
        @(negedge rd_clk);
        checks++; if (s_if.valid !== 1'b1 || s_if.data !== 8'h63) begin
            errors++; $display("FAIL flush_next: m_valid=%b m_data=%h required 1/63", s_if.valid, s_if.data);
        end
        cyc();
        @(negedge rd_clk);
        checks++; if (s_if.valid !== 1'b1 || s_if.data !== 8'h64) begin
            errors++; $display("FAIL flush_next2: m_valid=%b m_data=%h required 1/64", s_if.valid, s_if.data);
        end
        cyc();
        @(negedge rd_clk);
        checks++; if (s_if.valid !== 1'b0) begin errors++; $display("FAIL flush_end: m_valid=%b required 0", s_if.valid); end
    endtask

    task automatic test_reset_mid();
        cyc();
        flush = 1'b1;
        s_if.ready = 1'b1;
        write_words(8'h81, 8);
        cyc();
        flush = 1'b0;
        cyc();
        cyc();
        @(negedge rd_clk);
        checks++; if (s_if.valid !== 1'b1 || s_if.data !== 8'h81) begin
            errors++; $display("FAIL rstmid_first: m_valid=%b m_data=%h required 1/81", s_if.valid, s_if.data);
        end
        cyc();
        rd_rst = 1'b1;
        @(negedge rd_clk);
        checks++; if (fifo_rd_en !== 1'b0 || s_if.data !== 8'h82) begin
            errors++; $display("FAIL rstmid_assert: fifo_rd_en=%b m_data=%h required 0/82", fifo_rd_en, s_if.data);
        end
        cyc();
        @(negedge rd_clk);
        checks++; if (s_if.valid !== 1'b0 || s_if.data !== 8'h00 || fifo_rd_en !== 1'b0) begin
            errors++; $display("FAIL rstmid_clear: m_valid=%b m_data=%h fifo_rd_en=%b required 0/00/0", s_if.valid, s_if.data, fifo_rd_en);
        end
`ifdef FIFO_RD_STATS_EN
        checks++; if (rd_count !== 32'd0) begin errors++; $display("FAIL rstmid_count: rd_count=%0d required 0", rd_count); end
`endif
        cyc();
        @(negedge rd_clk);
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_hold: fifo_rd_en=%b required 0", fifo_rd_en); end
        cyc();
        rd_rst = 1'b0;
        @(negedge rd_clk);
        checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL rstmid_resume: fifo_rd_en=%b required 1", fifo_rd_en); end
        cyc();
        for (int i = 0; i < 5; i++) begin
            cyc();
            @(negedge rd_clk);
            checks++; if (s_if.valid !== 1'b1 || s_if.data !== 8'h84 + 8'(i)) begin
                errors++; $display("FAIL rstmid_word%0d: m_valid=%b m_data=%h required 1/%h", i, s_if.valid, s_if.data, 8'h84 + 8'(i));
            end
        end
        cyc();
        @(negedge rd_clk);
        checks++; if (s_if.valid !== 1'b0) begin errors++; $display("FAIL rstmid_end: m_valid=%b required 0", s_if.valid); end
    endtask

`ifdef FIFO_RD_STATS_EN
    task automatic test_stats();
        @(negedge rd_clk);
        checks++; if (rd_count !== 32'd5) begin errors++; $display("FAIL stats_after_reset: rd_count=%0d required 5", rd_count); end
        cyc();
        flush = 1'b1;
        s_if.ready = 1'b1;
        write_words(8'hA0, 15);
        cyc();
        flush = 1'b0;
        repeat (24) cyc();
        @(negedge rd_clk);
        checks++; if (rd_count !== 32'd20) begin errors++; $display("FAIL stats_twenty: rd_count=%0d required 20", rd_count); end
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        @(negedge rd_clk);
        checks++; if (rd_count !== 32'd20) begin errors++; $display("FAIL stats_flush: rd_count=%0d required 20", rd_count); end
    endtask
`endif

    initial begin
        rd_rst     = 1'b1;
        fifo_rst   = 1'b1;
        flush      = 1'b1;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        s_if.ready = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_toggle();
        test_flush();
        test_reset_mid();
`ifdef FIFO_RD_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
